// File: rtl/mips_pkg.sv
// Shared constants for the MIPS pipeline front end.
package mips_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [Width-1:0] count
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {Width{1'b1}})) begin
      count_d = count_q + {{(Width-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/if_stage_ctrl.sv
// Instruction-fetch stage: PC register, IF/ID register, stall/flush/redirect handling and
// saturating stall/flush event counters.
module if_stage_ctrl
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             data_hazard,
  input  logic             if_flush,
  input  logic             branch_taken,
  input  logic             jump,
  input  logic [XLEN-1:0]  branch_target,
  input  logic [XLEN-1:0]  jump_target,
  input  logic [XLEN-1:0]  imem_instr,
  output logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  if_id_instr,
  output logic [XLEN-1:0]  if_id_pc_plus4,
  output logic             if_id_valid,
  output logic             id_ex_bubble,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic            stall;
  logic            flush_eff;
  logic [XLEN-1:0] pc_plus4;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] if_id_instr_q, if_id_instr_d;
  logic [XLEN-1:0] if_id_pc_plus4_q, if_id_pc_plus4_d;
  logic            if_id_valid_q, if_id_valid_d;

  // A stall masks the flush: branch outcome in ID is computed from stale operands.
  assign stall     = ~data_hazard;
  assign flush_eff = if_flush & ~stall;
  assign pc_plus4  = pc_q + PC_STEP;

  always_comb begin
    pc_d = pc_plus4;
    if (stall) begin
      pc_d = pc_q;
    end else if (jump) begin
      pc_d = jump_target;
    end else if (branch_taken) begin
      pc_d = branch_target;
    end
  end

  always_comb begin
    if_id_instr_d    = imem_instr;
    if_id_pc_plus4_d = pc_plus4;
    if_id_valid_d    = 1'b1;
    if (stall) begin
      if_id_instr_d    = if_id_instr_q;
      if_id_pc_plus4_d = if_id_pc_plus4_q;
      if_id_valid_d    = if_id_valid_q;
    end else if (flush_eff) begin
      if_id_instr_d = NOP_INSTR;
      if_id_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q             <= RESET_PC;
      if_id_instr_q    <= '0;
      if_id_pc_plus4_q <= '0;
      if_id_valid_q    <= 1'b0;
    end else begin
      pc_q             <= pc_d;
      if_id_instr_q    <= if_id_instr_d;
      if_id_pc_plus4_q <= if_id_pc_plus4_d;
      if_id_valid_q    <= if_id_valid_d;
    end
  end

  sat_counter #(
    .Width(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (stall),
    .count(stall_cnt)
  );

  sat_counter #(
    .Width(CNT_W)
  ) u_flush_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (flush_eff),
    .count(flush_cnt)
  );

  assign pc             = pc_q;
  assign if_id_instr    = if_id_instr_q;
  assign if_id_pc_plus4 = if_id_pc_plus4_q;
  assign if_id_valid    = if_id_valid_q;
  assign id_ex_bubble   = stall;

endmodule

// File: tb/tb_if_stage_ctrl.sv
// Directed bench for if_stage_ctrl with hand-computed expectations; counters narrowed to 4 bits.
module tb_if_stage_ctrl;

  localparam int unsigned CntW = 4;

  logic            clk;
  logic            rst_n;
  logic            data_hazard;
  logic            if_flush;
  logic            branch_taken;
  logic            jump;
  logic [31:0]     branch_target;
  logic [31:0]     jump_target;
  logic [31:0]     imem_instr;
  logic [31:0]     pc;
  logic [31:0]     if_id_instr;
  logic [31:0]     if_id_pc_plus4;
  logic            if_id_valid;
  logic            id_ex_bubble;
  logic [CntW-1:0] stall_cnt;
  logic [CntW-1:0] flush_cnt;

  int n_total;
  int n_bad;

  if_stage_ctrl #(
    .RESET_PC(32'h0000_0000),
    .CNT_W   (CntW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .data_hazard   (data_hazard),
    .if_flush      (if_flush),
    .branch_taken  (branch_taken),
    .jump          (jump),
    .branch_target (branch_target),
    .jump_target   (jump_target),
    .imem_instr    (imem_instr),
    .pc            (pc),
    .if_id_instr   (if_id_instr),
    .if_id_pc_plus4(if_id_pc_plus4),
    .if_id_valid   (if_id_valid),
    .id_ex_bubble  (id_ex_bubble),
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one rising edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, ".pc"}, pc, 32'h0);
    check_eq({tag, ".instr"}, if_id_instr, 32'h0);
    check_eq({tag, ".pc4"}, if_id_pc_plus4, 32'h0);
    check_eq({tag, ".valid"}, {31'd0, if_id_valid}, 32'd0);
    check_eq({tag, ".scnt"}, {28'd0, stall_cnt}, 32'd0);
    check_eq({tag, ".fcnt"}, {28'd0, flush_cnt}, 32'd0);
  endtask

  initial begin
    n_total       = 0;
    n_bad         = 0;
    rst_n         = 1'b0;
    data_hazard   = 1'b1;
    if_flush      = 1'b0;
    branch_taken  = 1'b0;
    jump          = 1'b0;
    branch_target = 32'h0;
    jump_target   = 32'h0;
    imem_instr    = 32'h2008_0005;

    #1;
    check_reset_state("rst");
    check_eq("rst.bubble0", {31'd0, id_ex_bubble}, 32'd0);
    data_hazard = 1'b0;
    #1;
    check_eq("rst.bubble_comb", {31'd0, id_ex_bubble}, 32'd1);
    data_hazard = 1'b1;

    // Release between edges (edges at 5, 15, ...).
    #10;
    rst_n = 1'b1;

    step();
    check_eq("run1.pc", pc, 32'h4);
    check_eq("run1.valid", {31'd0, if_id_valid}, 32'd1);
    check_eq("run1.pc4", if_id_pc_plus4, 32'h4);
    check_eq("run1.instr", if_id_instr, 32'h2008_0005);
    step();
    check_eq("run2.pc", pc, 32'h8);
    step();
    check_eq("run3.pc", pc, 32'hC);
    step();
    check_eq("run4.pc", pc, 32'h10);
    check_eq("run4.pc4", if_id_pc_plus4, 32'h10);

    // Load-use stall for two cycles at pc=0x10.
    data_hazard = 1'b0;
    imem_instr  = 32'hDEAD_BEEF;
    #1;
    check_eq("stall.bubble_comb", {31'd0, id_ex_bubble}, 32'd1);
    step();
    check_eq("stall1.pc", pc, 32'h10);
    check_eq("stall1.instr", if_id_instr, 32'h2008_0005);
    check_eq("stall1.scnt", {28'd0, stall_cnt}, 32'd1);
    check_eq("stall1.bubble", {31'd0, id_ex_bubble}, 32'd1);
    step();
    check_eq("stall2.pc", pc, 32'h10);
    check_eq("stall2.pc4", if_id_pc_plus4, 32'h10);
    check_eq("stall2.scnt", {28'd0, stall_cnt}, 32'd2);
    data_hazard = 1'b1;
    imem_instr  = 32'h8C01_0000;
    #1;
    check_eq("unstall.bubble", {31'd0, id_ex_bubble}, 32'd0);
    step();
    check_eq("resume.pc", pc, 32'h14);
    check_eq("resume.instr", if_id_instr, 32'h8C01_0000);
    check_eq("resume.pc4", if_id_pc_plus4, 32'h14);
    check_eq("resume.scnt", {28'd0, stall_cnt}, 32'd2);

    // Taken branch with flush.
    branch_taken  = 1'b1;
    if_flush      = 1'b1;
    branch_target = 32'h40;
    step();
    check_eq("br.pc", pc, 32'h40);
    check_eq("br.instr", if_id_instr, 32'h0);
    check_eq("br.valid", {31'd0, if_id_valid}, 32'd0);
    check_eq("br.pc4", if_id_pc_plus4, 32'h18);
    check_eq("br.fcnt", {28'd0, flush_cnt}, 32'd1);
    branch_taken = 1'b0;
    if_flush     = 1'b0;
    step();
    check_eq("br_next.pc", pc, 32'h44);
    check_eq("br_next.valid", {31'd0, if_id_valid}, 32'd1);
    check_eq("br_next.instr", if_id_instr, 32'h8C01_0000);

    // Stall together with flush and jump: hold everything.
    data_hazard = 1'b0;
    if_flush    = 1'b1;
    jump        = 1'b1;
    jump_target = 32'h80;
    step();
    check_eq("sim.pc", pc, 32'h44);
    check_eq("sim.fcnt", {28'd0, flush_cnt}, 32'd1);
    check_eq("sim.valid", {31'd0, if_id_valid}, 32'd1);
    check_eq("sim.scnt", {28'd0, stall_cnt}, 32'd3);
    data_hazard = 1'b1;
    step();
    check_eq("sim2.pc", pc, 32'h80);
    check_eq("sim2.fcnt", {28'd0, flush_cnt}, 32'd2);
    check_eq("sim2.valid", {31'd0, if_id_valid}, 32'd0);
    if_flush = 1'b0;
    jump     = 1'b0;

    // Jump beats branch; no flush without if_flush.
    jump          = 1'b1;
    branch_taken  = 1'b1;
    jump_target   = 32'h100;
    branch_target = 32'h200;
    step();
    check_eq("prio.pc", pc, 32'h100);
    check_eq("prio.valid", {31'd0, if_id_valid}, 32'd1);
    check_eq("prio.fcnt", {28'd0, flush_cnt}, 32'd2);
    branch_taken = 1'b0;

    // Wrap from the top of the address space.
    jump_target = 32'hFFFF_FFFC;
    step();
    check_eq("wrap0.pc", pc, 32'hFFFF_FFFC);
    jump = 1'b0;
    step();
    check_eq("wrap.pc", pc, 32'h0);
    check_eq("wrap.pc4", if_id_pc_plus4, 32'h0);

    // Long stall saturates the 4-bit counter (3 + 20 > 15).
    data_hazard = 1'b0;
    for (int i = 0; i < 12; i++) step();
    check_eq("sat_mid.scnt", {28'd0, stall_cnt}, 32'd15);
    for (int i = 0; i < 8; i++) step();
    check_eq("sat.scnt", {28'd0, stall_cnt}, 32'd15);
    check_eq("sat.pc", pc, 32'h0);

    // Async reset between edges, mid-stall.
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("arst");
    check_eq("arst.bubble", {31'd0, id_ex_bubble}, 32'd1);
    data_hazard = 1'b1;
    #1;
    check_eq("arst.bubble_off", {31'd0, id_ex_bubble}, 32'd0);
    rst_n = 1'b1;
    step();
    check_eq("post_rst.pc", pc, 32'h4);
    check_eq("post_rst.valid", {31'd0, if_id_valid}, 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
